// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives guess into an external
// comparator, MSB first. Optional flag-sanity checking via SAR_FLAG_CHECK_EN.
module sar_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int STEPW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [STEPW-1:0] steps
`ifdef SAR_FLAG_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRIAL = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [IDXW-1:0]  bit_idx;
  logic [STEPW-1:0] cnt;
  logic [WIDTH-1:0] trial_guess;
  logic             last_step;

  assign busy      = (state == TRIAL);
  assign done      = (state == DONE);
  assign last_step = (bit_idx == '0);

  // The bit under test is kept only on gt; lt and the all-zero case clear it.
  always_comb begin
    trial_guess          = guess;
    trial_guess[bit_idx] = gt;
    if (!last_step) trial_guess[bit_idx - IDXW'(1)] = 1'b1;
  end

`ifdef SAR_FLAG_CHECK_EN
  logic flag_bad;
  assign flag_bad = !$onehot({gt, eq, lt});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      guess   <= '0;
      result  <= '0;
      steps   <= '0;
      bit_idx <= IDXW'(WIDTH - 1);
      cnt     <= '0;
`ifdef SAR_FLAG_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            guess   <= {1'b1, {(WIDTH-1){1'b0}}};
            bit_idx <= IDXW'(WIDTH - 1);
            cnt     <= STEPW'(1);
`ifdef SAR_FLAG_CHECK_EN
            err     <= 1'b0;
`endif
            state   <= TRIAL;
          end
        end
        TRIAL: begin
`ifdef SAR_FLAG_CHECK_EN
          if (flag_bad) begin
            err    <= 1'b1;
            result <= '0;
            steps  <= cnt;
            state  <= DONE;
          end else
`endif
          if (eq) begin
            result <= guess;
            steps  <= cnt;
            state  <= DONE;
          end else if (last_step) begin
            guess  <= trial_guess;
            result <= trial_guess;
            steps  <= cnt;
            state  <= DONE;
          end else begin
            guess   <= trial_guess;
            bit_idx <= bit_idx - IDXW'(1);
            cnt     <= cnt + STEPW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
